// File: rtl/herring_gpu_pkg.sv
// Shared definitions for the herring GPU blocks: framebuffer defaults,
// pixel field widths, fill FSM encoding and small coordinate helpers.
package herring_gpu_pkg;

    localparam int FB_WIDTH_DEF  = 160;
    localparam int FB_HEIGHT_DEF = 120;
    localparam int COLOR_W       = 3;
    localparam int COORD_W       = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_FILL   = 2'd2,
        ST_FINISH = 2'd3
    } fill_state_e;

    // Smaller of two coordinates.
    function automatic coord_t coord_min(input coord_t a, input coord_t b);
        coord_t r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // Larger of two coordinates.
    function automatic coord_t coord_max(input coord_t a, input coord_t b);
        coord_t r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational rectangle normaliser: orders the two corners and clips the
// far edges to the framebuffer. Flags a rectangle that lies wholly outside.
module gpu_rect_clip
    import herring_gpu_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    output logic [COORD_W-1:0] xmin_o,
    output logic [COORD_W-1:0] xmax_o,
    output logic [COORD_W-1:0] ymin_o,
    output logic [COORD_W-1:0] ymax_o,
    output logic               empty_o
);

    // Last legal coordinate on each axis; comparing against these instead of
    // FB_WIDTH/FB_HEIGHT keeps every compare inside the 8-bit coordinate range.
    localparam coord_t X_LAST = coord_t'(FB_WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(FB_HEIGHT - 1);

    coord_t xlo_s;
    coord_t xhi_s;
    coord_t ylo_s;
    coord_t yhi_s;

    // Order corners, clip the far edges and detect a fully off-screen rectangle.
    always_comb begin
        xlo_s   = coord_min(x0_i, x1_i);
        xhi_s   = coord_max(x0_i, x1_i);
        ylo_s   = coord_min(y0_i, y1_i);
        yhi_s   = coord_max(y0_i, y1_i);
        xmin_o  = xlo_s;
        ymin_o  = ylo_s;
        xmax_o  = coord_min(xhi_s, X_LAST);
        ymax_o  = coord_min(yhi_s, Y_LAST);
        empty_o = (xlo_s > X_LAST) || (ylo_s > Y_LAST);
    end

endmodule

// File: rtl/gpu_fill_engine.sv
// Rectangle fill engine: latches a fill command, normalises/clips it once,
// then streams one pixel write per accepted handshake in raster order.
module gpu_fill_engine
    import herring_gpu_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic               SYS_CLOCK,
    input  logic               RESET,
    input  logic [COORD_W-1:0] CMD_X0,
    input  logic [COORD_W-1:0] CMD_Y0,
    input  logic [COORD_W-1:0] CMD_X1,
    input  logic [COORD_W-1:0] CMD_Y1,
    input  logic [COLOR_W-1:0] CMD_COLOR,
    input  logic               CMD_START,
    input  logic               CMD_ABORT,
    output logic [COORD_W-1:0] PIX_X,
    output logic [COORD_W-1:0] PIX_Y,
    output logic [COLOR_W-1:0] PIX_COLOR,
    output logic               PIX_WE,
    input  logic               PIX_READY,
    output logic               BUSY,
    output logic               DONE
);

    fill_state_e state_q, state_d;

    // Raw command as latched in IDLE.
    coord_t x0_q, x0_d;
    coord_t y0_q, y0_d;
    coord_t x1_q, x1_d;
    coord_t y1_q, y1_d;
    color_t color_q, color_d;

    // Clipped bounds captured in SETUP; ymin is only needed as the cursor seed.
    coord_t xmin_q, xmin_d;
    coord_t xmax_q, xmax_d;
    coord_t ymax_q, ymax_d;

    // Raster cursor; doubles as the PIX_X/PIX_Y output registers.
    coord_t x_q, x_d;
    coord_t y_q, y_d;

    coord_t clip_xmin_s;
    coord_t clip_xmax_s;
    coord_t clip_ymin_s;
    coord_t clip_ymax_s;
    logic   clip_empty_s;

    gpu_rect_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .x0_i    (x0_q),
        .y0_i    (y0_q),
        .x1_i    (x1_q),
        .y1_i    (y1_q),
        .xmin_o  (clip_xmin_s),
        .xmax_o  (clip_xmax_s),
        .ymin_o  (clip_ymin_s),
        .ymax_o  (clip_ymax_s),
        .empty_o (clip_empty_s)
    );

    // Next-state logic: command latch, setup, raster advance and abort.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        x_d     = x_q;
        y_d     = y_q;

        case (state_q)
            ST_IDLE: begin
                // ABORT beats START when both arrive together.
                if (CMD_START && !CMD_ABORT) begin
                    x0_d    = CMD_X0;
                    y0_d    = CMD_Y0;
                    x1_d    = CMD_X1;
                    y1_d    = CMD_Y1;
                    color_d = CMD_COLOR;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (CMD_ABORT) begin
                    state_d = ST_IDLE;
                end else if (clip_empty_s) begin
                    state_d = ST_FINISH;
                end else begin
                    xmin_d  = clip_xmin_s;
                    xmax_d  = clip_xmax_s;
                    ymax_d  = clip_ymax_s;
                    x_d     = clip_xmin_s;
                    y_d     = clip_ymin_s;
                    state_d = ST_FILL;
                end
            end

            ST_FILL: begin
                // A beat accepted in the abort cycle still counts as written;
                // the cursor simply stops moving.
                if (CMD_ABORT) begin
                    state_d = ST_IDLE;
                end else if (PIX_READY) begin
                    if (x_q == xmax_q) begin
                        if (y_q == ymax_q) begin
                            state_d = ST_FINISH;
                        end else begin
                            x_d = xmin_q;
                            y_d = y_q + coord_t'(1);
                        end
                    end else begin
                        x_d = x_q + coord_t'(1);
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge SYS_CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    always_comb begin
        PIX_X     = x_q;
        PIX_Y     = y_q;
        PIX_COLOR = color_q;
        PIX_WE    = (state_q == ST_FILL);
        BUSY      = (state_q != ST_IDLE);
        DONE      = (state_q == ST_FINISH);
    end

endmodule
